// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles,
// EX redirects, data-memory wait states and HALT drain, plus perf counters.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_halt,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  input  logic              mem_req,
  input  logic              mem_ready,
  input  logic              wb_halt,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              ifid_clr,
  output logic              idex_we,
  output logic              idex_clr,
  output logic              exmem_we,
  output logic              memwb_bubble,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    DRAIN,
    HALTED
  } state_t;

  state_t state, state_nxt;
  logic   from_drain, from_drain_nxt;
  logic   memstall, loaduse, rs1_hit, rs2_hit;
  logic   freeze, run_eval, drain_eval;
  logic   stall_inc, flush_inc;

  assign memstall = mem_req & ~mem_ready;
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign loaduse  = ex_memread & (ex_rd != '0) & (rs1_hit | rs2_hit);
  assign halted   = (state == HALTED);

  always_comb begin
    pc_we          = 1'b1;
    ifid_we        = 1'b1;
    ifid_clr       = 1'b0;
    idex_we        = 1'b1;
    idex_clr       = 1'b0;
    exmem_we       = 1'b1;
    memwb_bubble   = 1'b0;
    state_nxt      = state;
    from_drain_nxt = from_drain;
    flush_inc      = 1'b0;
    freeze         = 1'b0;
    run_eval       = 1'b0;
    drain_eval     = 1'b0;

    if (!rst_n) begin
      pc_we          = 1'b0;
      ifid_we        = 1'b0;
      idex_we        = 1'b0;
      exmem_we       = 1'b0;
      ifid_clr       = 1'b1;
      idex_clr       = 1'b1;
      memwb_bubble   = 1'b1;
      state_nxt      = RUN;
      from_drain_nxt = 1'b0;
    end else begin
      // Decide which rule set applies this cycle; a released MEM_WAIT
      // behaves exactly like the state it was entered from.
      case (state)
        RUN: begin
          if (memstall) freeze = 1'b1;
          else          run_eval = 1'b1;
        end
        MEM_WAIT: begin
          if (memstall)        freeze = 1'b1;
          else if (from_drain) drain_eval = 1'b1;
          else                 run_eval = 1'b1;
        end
        DRAIN: begin
          if (memstall) freeze = 1'b1;
          else          drain_eval = 1'b1;
        end
        HALTED: begin
          pc_we        = 1'b0;
          ifid_we      = 1'b0;
          idex_we      = 1'b0;
          exmem_we     = 1'b0;
          ifid_clr     = 1'b1;
          idex_clr     = 1'b1;
          memwb_bubble = 1'b1;
        end
        default: state_nxt = RUN;
      endcase

      if (freeze) begin
        pc_we          = 1'b0;
        ifid_we        = 1'b0;
        idex_we        = 1'b0;
        exmem_we       = 1'b0;
        memwb_bubble   = 1'b1;
        state_nxt      = MEM_WAIT;
        from_drain_nxt = (state == DRAIN) | ((state == MEM_WAIT) & from_drain);
      end

      if (drain_eval) begin
        pc_we     = 1'b0;
        ifid_clr  = 1'b1;
        state_nxt = DRAIN;
      end

      if (run_eval) begin
        state_nxt = RUN;
        if (ex_redirect) begin
          ifid_clr  = 1'b1;
          idex_clr  = 1'b1;
          flush_inc = 1'b1;
        end else if (loaduse) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idex_clr = 1'b1;
        end else if (id_halt) begin
          pc_we     = 1'b0;
          ifid_clr  = 1'b1;
          state_nxt = DRAIN;
        end
      end

      // wb_halt stops the core from RUN or DRAIN (and on a wait release),
      // but not while a wait state is still holding the pipeline frozen.
      if (wb_halt && (run_eval || drain_eval || (freeze && state != MEM_WAIT)))
        state_nxt = HALTED;
    end
  end

  assign stall_inc = rst_n & (state != HALTED) & ~pc_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      from_drain <= 1'b0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      from_drain <= from_drain_nxt;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the write-enable and clear controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers. It covers four cases: load-use hazards, EX-resolved redirects (branch/jal/jalr), data-memory wait states, and HALT drain-to-stop sequencing. It also keeps saturating stall/flush performance counters.

Parameters:
REG_AW, 5, register-index width
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock
rst_n  in  1  reset
id_rs1  in  REG_AW  rs1 of instruction in ID
id_rs2  in  REG_AW  rs2 of instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
id_halt  in  1  ID instruction is HALT
ex_memread  in  1  ID/EX MemRead
ex_rd  in  REG_AW  ID/EX rd
ex_redirect  in  1  EX resolved taken branch/Jump/Jalr
mem_req  in  1  EX/MEM MemRead|MemWrite
mem_ready  in  1  data memory completes access this cycle
wb_halt  in  1  MEM/WB Halt
pc_we  out  1  PC update enable
ifid_we  out  1  IF/ID load enable
ifid_clr  out  1  IF/ID load bubble (priority over ifid_we)
idex_we  out  1  ID/EX load enable
idex_clr  out  1  ID/EX load bubble
exmem_we  out  1  EX/MEM load enable
memwb_bubble  out  1  MEM/WB loads bubble
halted  out  1  core stopped
stall_cnt  out  CNT_W  cycles with pc_we=0 outside HALTED
flush_cnt  out  CNT_W  accepted redirects

Behaviour:
- Reset is synchronous and active-low on rst_n; single clock clk, all state on rising edge.
- Reset values: state=RUN, halted=0, stall_cnt=0, flush_cnt=0.
- While rst_n=0, the combinational outputs are forced to: pc_we=ifid_we=idex_we=exmem_we=0, ifid_clr=idex_clr=memwb_bubble=1.
- FSM states: RUN, MEM_WAIT, DRAIN, HALTED.
- Outputs are combinational from state plus inputs. Default: all *_we=1, all clr/bubble=0.
- Condition definitions:
  - memstall = mem_req & ~mem_ready
  - loaduse = ex_memread & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd))
- Priority in RUN, highest first:
  1. memstall: freeze; pc/ifid/idex/exmem_we=0, memwb_bubble=1; next state MEM_WAIT.
  2. ex_redirect: pc_we=1 (target), ifid_clr=1, idex_clr=1; flush_cnt++. A simultaneous id_halt is squashed.
  3. loaduse: pc_we=0, ifid_we=0, idex_clr=1. Exactly one bubble per hazard, because the next cycle ex_memread=0.
  4. id_halt: HALT advances into ID/EX; pc_we=0, ifid_clr=1; next state DRAIN.
- MEM_WAIT: freeze as in case 1 each cycle while mem_ready=0.
  - On the cycle mem_ready=1: no freeze, and the RUN priority list (items 2-4) is evaluated that cycle.
  - Return to RUN, or to DRAIN if entered from DRAIN; track the origin with one register bit.
  - A redirect or loaduse held during the wait is serviced on the release cycle, never lost.
- DRAIN: pc_we=0, ifid_clr=1 every cycle. ex_redirect and loaduse are ignored, since no older instruction can redirect.
  - memstall freezes as in MEM_WAIT, with origin=DRAIN.
  - wb_halt=1 -> HALTED.
- HALTED: all *_we=0, ifid_clr=idex_clr=memwb_bubble=1, halted=1. Held until rst_n=0; all inputs ignored.
- wb_halt seen in RUN is treated as in DRAIN, a defensive transition to HALTED.
- stall_cnt increments every cycle pc_we=0 in RUN/MEM_WAIT/DRAIN. flush_cnt increments per accepted redirect. Both saturate at 2^CNT_W-1 with no wrap.
- Reset asserted mid-MEM_WAIT or mid-DRAIN returns to RUN next edge and clears the counters.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> one cycle pc_we=0, ifid_we=0, idex_clr=1, stall_cnt=1. Same with ex_rd=0 -> no stall.
- Redirect with simultaneous loaduse and id_halt -> pc_we=1, ifid_clr=idex_clr=1, flush_cnt=1, state stays RUN.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles with ex_redirect=1 held -> 3 frozen cycles (memwb_bubble=1), then redirect accepted on release cycle, stall_cnt=3, flush_cnt=1.
- Halt: id_halt=1 in RUN -> DRAIN, pc_we=0. wb_halt=1 three cycles later -> halted=1 next cycle; later toggles of ex_redirect/mem_req have no effect.
- Reset mid-DRAIN with a memstall pending: rst_n=0 one cycle -> state RUN, halted=0, counters 0, controls return to defaults.
- Saturation: force 70000 stall cycles with CNT_W=16 -> stall_cnt=65535.
